red_pitaya_pwm_dac: RTL

//  Four-channel PWM DAC generator. Consumes the 24-bit dac_a..dac_d words from the analog mixed-signal

---
 rtl/red_pitaya_pwm_dac_pkg.sv | 27 ++
 rtl/red_pitaya_pwm_dac_if.sv | 23 ++
 rtl/red_pitaya_pwm_dac_ch.sv | 55 +++++
 rtl/red_pitaya_pwm_dac.sv | 61 ++++++
 4 files changed

// File: rtl/red_pitaya_pwm_dac_pkg.sv
// Shared constants, types and helpers for the four-channel PWM DAC.
// Dither is enabled by defining PWM_DITHER_EN; the default build uses the duty byte only.
package red_pitaya_pwm_pkg;

    localparam int PWM_FULL = 156;
    localparam int PWM_CW   = 8;

    localparam int CFG_W    = 24;
    localparam int DUTY_MSB = 23;
    localparam int DUTY_LSB = 16;
    localparam int PAT_MSB  = 15;
    localparam int PAT_LSB  = 0;

    localparam int SEQ_LEN  = 16;
    localparam int SEQ_W    = 4;
    localparam int NUM_CH   = 4;

    typedef logic [CFG_W-1:0] cfg_t;
    typedef logic [SEQ_W-1:0] seq_t;
    typedef logic [8:0]       width_t;

    // Pulse width saturates at the period length; anything above is constant high.
    function automatic width_t clamp_width(width_t v, int full);
        return (int'(v) > full) ? width_t'(full) : v;
    endfunction

endpackage

// File: rtl/red_pitaya_pwm_dac_if.sv
// Configuration words in, PWM pins and frame sync out; master drives cfg, slave is the DAC.
import red_pitaya_pwm_pkg::*;

interface red_pitaya_pwm_dac_if;

    cfg_t              cfg_a_i;
    cfg_t              cfg_b_i;
    cfg_t              cfg_c_i;
    cfg_t              cfg_d_i;
    logic [NUM_CH-1:0] pwm_o;
    logic              sync_o;

    modport master (
        output cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i,
        input  pwm_o, sync_o
    );

    modport slave (
        input  cfg_a_i, cfg_b_i, cfg_c_i, cfg_d_i,
        output pwm_o, sync_o
    );

endinterface

// File: rtl/red_pitaya_pwm_dac_ch.sv
// One PWM channel: shadow word loaded at the period boundary, dithered width, registered pin.
// Dither bit selection is compiled in only when PWM_DITHER_EN is defined.
import red_pitaya_pwm_pkg::*;

module red_pitaya_pwm_ch #(
    parameter int FULL = PWM_FULL,
    parameter int CW   = PWM_CW
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic [CW-1:0] cnt,
    input  seq_t          seq,
    input  logic          load,
    input  cfg_t          cfg,
    output logic          pwm
);

    cfg_t   shadow;
    logic   dither_bit;
    width_t width_raw;
    width_t width_eff;

    // NOTE: the shadow word is reset so the first period after reset is guaranteed low.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= cfg;
        end
    end

`ifdef PWM_DITHER_EN
    logic [SEQ_LEN-1:0] pattern;
    assign pattern    = shadow[PAT_MSB:PAT_LSB];
    assign dither_bit = pattern[seq];
`else
    wire unused_pattern = ^{shadow[PAT_MSB:PAT_LSB], seq};
    assign dither_bit = 1'b0;
`endif

    always_comb begin
        width_raw = {1'b0, shadow[DUTY_MSB:DUTY_LSB]} + {8'd0, dither_bit};
        width_eff = clamp_width(width_raw, FULL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (int'(cnt) < int'(width_eff));
        end
    end

endmodule

// File: rtl/red_pitaya_pwm_dac.sv
// Four-channel PWM DAC: period counter, dither sequence index and frame sync shared by all channels.
// Define PWM_DITHER_EN to add the 16-period dither; otherwise only the duty byte sets the width.
import red_pitaya_pwm_pkg::*;

module red_pitaya_pwm_dac #(
    parameter int FULL = PWM_FULL,
    parameter int CW   = PWM_CW
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    red_pitaya_pwm_dac_if.slave  bus
);

    logic [CW-1:0]     cnt;
    seq_t              seq;
    logic              boundary;
    logic              sync_q;
    logic [NUM_CH-1:0] pwm_bits;
    cfg_t              cfg [NUM_CH];

    assign boundary = (cnt == CW'(FULL - 1));

    // seq starts at all-ones so the first loaded period wraps it to 0.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt    <= '0;
            seq    <= '1;
            sync_q <= 1'b0;
        end else begin
            cnt    <= boundary ? '0 : cnt + 1'b1;
            if (boundary) begin
                seq <= seq + 1'b1;
            end
            sync_q <= (cnt == '0) && (seq == '0);
        end
    end

    assign cfg[0] = bus.cfg_a_i;
    assign cfg[1] = bus.cfg_b_i;
    assign cfg[2] = bus.cfg_c_i;
    assign cfg[3] = bus.cfg_d_i;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        red_pitaya_pwm_ch #(
            .FULL (FULL),
            .CW   (CW)
        ) u_ch (
            .clk_i  (clk_i),
            .rstn_i (rstn_i),
            .cnt    (cnt),
            .seq    (seq),
            .load   (boundary),
            .cfg    (cfg[ch]),
            .pwm    (pwm_bits[ch])
        );
    end

    assign bus.pwm_o  = pwm_bits;
    assign bus.sync_o = sync_q;

endmodule
